// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial add/subtract controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/module_full_adder.sv
// Team 1-bit full adder cell; purely combinational.
module module_full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/module_serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full adder cell is reused WIDTH
// times, LSB first, with a carry flip-flop closing the loop between bits.
module module_serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             w_accept;
  logic             w_lastBit;
  logic             w_faSum;
  logic             w_faCout;

  // A request is only honoured while idle or in the single done cycle.
  assign w_accept  = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_lastBit = (r_cnt == LAST_BIT);

  module_full_adder u_fullAdder (
    .A    (r_a[0]),
    .B    (r_b[0]),
    .Cin  (r_carry),
    .S    (w_faSum),
    .Cout (w_faCout)
  );

  // State register; reset drops any in-flight operation without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: RUN lasts exactly WIDTH cycles, DONE lasts one.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_nextState = S_RUN;
      S_RUN:   if (w_lastBit) w_nextState = S_DONE;
      S_DONE:  w_nextState = w_accept ? S_RUN : S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state register only.
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (r_state)
      S_RUN:   busy_o = 1'b1;
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath: load operands on accept, then shift one bit per RUN cycle.
  // Subtraction is A + ~B + 1, so B is inverted at load and carry seeded to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a_i;
      r_b     <= sub_i ? ~b_i : b_i;
      r_carry <= sub_i ? 1'b1 : cin_i;
      r_sum   <= '0;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sum   <= {w_faSum, r_sum[WIDTH-1:1]};
      r_carry <= w_faCout;
      if (w_lastBit) begin
        r_cout <= w_faCout;
        r_ovf  <= r_carry ^ w_faCout;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign sum_o  = r_sum;
  assign cout_o = r_cout;
  assign ovf_o  = r_ovf;

endmodule

// File: tb/tb_module_serial_add_ctrl.sv
// Self-checking bench for the bit-serial add/subtract controller (WIDTH=8).
module tb_module_serial_add_ctrl;

  localparam int W = 8;

  logic         clock;
  logic         reset;
  logic         startIn;
  logic         subIn;
  logic [W-1:0] aIn;
  logic [W-1:0] bIn;
  logic         cinIn;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks;
  int failures;

  typedef struct {
    string        name;
    bit           sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           cin;
    logic [W-1:0] expSum;
    bit           expCout;
    bit           expOvf;
  } vec_t;

  vec_t vecs[5];

  module_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk     (clock),
    .rst     (reset),
    .start_i (startIn),
    .sub_i   (subIn),
    .a_i     (aIn),
    .b_i     (bIn),
    .cin_i   (cinIn),
    .busy_o  (busy),
    .done_o  (done),
    .sum_o   (sum),
    .cout_o  (cout),
    .ovf_o   (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  task automatic refModel(input bit sub, input logic [W-1:0] a, input logic [W-1:0] b, input bit cin,
                          output logic [W-1:0] expSum, output bit expCout, output bit expOvf);
    int unsignedTotal;
    int signedTotal;
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    if (sub) begin
      unsignedTotal = int'(a) + int'(~b & 8'hFF) + 1;
      signedTotal   = sa - sb;
    end else begin
      unsignedTotal = int'(a) + int'(b) + int'(cin);
      signedTotal   = sa + sb + int'(cin);
    end
    expSum  = unsignedTotal[W-1:0];
    expCout = (unsignedTotal > 255);
    expOvf  = (signedTotal > 127) || (signedTotal < -128);
  endtask

  task automatic applyStimulus(input bit sub, input logic [W-1:0] a, input logic [W-1:0] b, input bit cin);
    @(negedge clock);
    subIn   = sub;
    aIn     = a;
    bIn     = b;
    cinIn   = cin;
    startIn = 1'b1;
    @(negedge clock);
    startIn = 1'b0;
  endtask

  // Called one negedge after the accepting edge; latency counts edges from it.
  task automatic waitDone(output int busyCycles, output int latency, output bit gotDone);
    busyCycles = 0;
    latency    = 1;
    gotDone    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        gotDone = 1'b1;
        break;
      end
      if (busy) busyCycles++;
      @(negedge clock);
      latency++;
    end
  endtask

  task automatic runAndCheck(input string name, input bit sub, input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit cin, input logic [W-1:0] expSum, input bit expCout, input bit expOvf);
    int  busyCycles;
    int  latency;
    bit  gotDone;
    applyStimulus(sub, a, b, cin);
    waitDone(busyCycles, latency, gotDone);
    checkOutput({name, " done"}, 32'(gotDone), 32'd1);
    if (gotDone) begin
      checkOutput({name, " latency"}, 32'(latency), 32'(W + 1));
      checkOutput({name, " busyCycles"}, 32'(busyCycles), 32'(W));
      checkOutput({name, " sum"}, 32'(sum), 32'(expSum));
      checkOutput({name, " cout"}, 32'(cout), 32'(expCout));
      checkOutput({name, " ovf"}, 32'(ovf), 32'(expOvf));
    end
  endtask

  task automatic countDones(input int cycles, output int dones, output int busies);
    dones  = 0;
    busies = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (done) dones++;
      if (busy) busies++;
    end
  endtask

  initial begin
    int           busyCycles;
    int           latency;
    bit           gotDone;
    int           dones;
    int           busies;
    logic [W-1:0] expSum;
    bit           expCout;
    bit           expOvf;
    bit           rSub;
    logic [W-1:0] rA;
    logic [W-1:0] rB;
    bit           rCin;

    checks   = 0;
    failures = 0;

    vecs[0] = '{"add5A3C",   1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{"addFF01",   1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{"addCin",    1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{"sub1020",   1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0};
    vecs[4] = '{"sub8001",   1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};

    reset   = 1'b1;
    startIn = 1'b0;
    subIn   = 1'b0;
    aIn     = '0;
    bIn     = '0;
    cinIn   = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset sum", 32'(sum), 32'd0);
    checkOutput("reset cout", 32'(cout), 32'd0);
    checkOutput("reset ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("idle busy", 32'(busy), 32'd0);

    for (int i = 0; i < 5; i++) begin
      runAndCheck(vecs[i].name, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin,
                  vecs[i].expSum, vecs[i].expCout, vecs[i].expOvf);
    end

    // Start during RUN must be ignored: result reflects the first operands.
    applyStimulus(1'b0, 8'h11, 8'h22, 1'b0);
    repeat (2) @(negedge clock);
    startIn = 1'b1;
    aIn     = 8'h77;
    bIn     = 8'h77;
    @(negedge clock);
    startIn = 1'b0;
    waitDone(busyCycles, latency, gotDone);
    checkOutput("ignore done", 32'(gotDone), 32'd1);
    checkOutput("ignore sum", 32'(sum), 32'h33);
    countDones(12, dones, busies);
    checkOutput("ignore extraDones", 32'(dones), 32'd0);

    // Back-to-back: start held during DONE launches the next operation.
    runAndCheck("b2bFirst", 1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    subIn   = 1'b0;
    aIn     = 8'h01;
    bIn     = 8'h01;
    cinIn   = 1'b0;
    startIn = 1'b1;
    @(negedge clock);
    startIn = 1'b0;
    checkOutput("b2b busyNow", 32'(busy), 32'd1);
    waitDone(busyCycles, latency, gotDone);
    checkOutput("b2b done", 32'(gotDone), 32'd1);
    checkOutput("b2b gap", 32'(latency), 32'(W + 1));
    checkOutput("b2b sum", 32'(sum), 32'h02);

    // Reset mid-run, after a result with cout=1 and ovf=1 is held.
    runAndCheck("preReset", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'hF0, 8'h0F, 1'b1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst sum", 32'(sum), 32'd0);
    checkOutput("rst cout", 32'(cout), 32'd0);
    checkOutput("rst ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    countDones(12, dones, busies);
    checkOutput("rst noDone", 32'(dones), 32'd0);
    checkOutput("rst noBusy", 32'(busies), 32'd0);
    runAndCheck("postReset", 1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      rSub = 1'($urandom_range(1, 0));
      rA   = 8'($urandom);
      rB   = 8'($urandom);
      rCin = 1'($urandom_range(1, 0));
      refModel(rSub, rA, rB, rCin, expSum, expCout, expOvf);
      runAndCheck($sformatf("rand%0d", i), rSub, rA, rB, rCin, expSum, expCout, expOvf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/module_serial_add_ctrl.md
# module_serial_add_ctrl

Bit-serial add/subtract controller that sequences one instance of the team's 1-bit full adder cell over WIDTH-bit operands, one bit per clock, LSB first. It accepts operands on a start pulse, runs the full adder WIDTH times through a carry flip-flop, and presents sum, carry-out and signed overflow with a one-cycle done pulse. It trades a WIDTH-bit ripple adder for a single full adder plus shift registers in area-constrained datapaths.

## Interface
- WIDTH, 8, operand/result width in bits; WIDTH >= 2 is required.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  request; sampled only in S_IDLE or S_DONE.
- sub_i  input  1  0 = A+B+cin_i; 1 = A-B (cin_i ignored); latched with start_i.
- a_i  input  WIDTH  operand A, latched on accepted start.
- b_i  input  WIDTH  operand B, latched on accepted start.
- cin_i  input  1  carry-in for add mode, latched on accepted start.
- busy_o  output  1  high while in S_RUN.
- done_o  output  1  one-cycle pulse in S_DONE.
- sum_o  output  WIDTH  result register; valid from done_o until the next accepted start.
- cout_o  output  1  final carry; in subtract mode 1 = no borrow (A >= B unsigned).
- ovf_o  output  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- States: S_IDLE, S_RUN, S_DONE. Reset state S_IDLE.
- S_IDLE: start_i=1 -> load A shift reg = a_i, B shift reg = sub_i ? ~b_i : b_i, carry reg = sub_i ? 1 : cin_i, bit counter = 0, result reg = 0; go S_RUN. start_i=0 -> stay.
- S_RUN: full adder inputs = A[0], B[0], carry reg. Each cycle: A, B shift right by 1; sum bit shifts into result MSB (result shifts right); carry reg <= full adder Cout; counter += 1. When counter == WIDTH-1 on that edge: capture ovf = carry-in of this bit XOR Cout, cout_o <= Cout, go S_DONE.
- start_i in S_RUN is ignored; no queuing.
- S_DONE: one cycle. start_i=1 -> accept exactly as in S_IDLE (back-to-back); else go S_IDLE.
- sum_o, cout_o, ovf_o hold their values in S_IDLE and S_DONE; sum_o is undefined (partial shift) during S_RUN.
- Counter width is $clog2(WIDTH); no wrap beyond WIDTH-1.
- Reset at any point (including mid S_RUN): on the next edge state = S_IDLE, counter = 0, carry = 0, shift regs = 0, sum_o = 0, cout_o = 0, ovf_o = 0. The in-flight operation is discarded with no done pulse.

## Timing
- Reset values: busy_o=0, done_o=0, sum_o=0, cout_o=0, ovf_o=0.
- start_i high at edge k (state S_IDLE/S_DONE) -> busy_o=1 for cycles after edges k..k+W-1 (W cycles); done_o=1 in the cycle after edge k+W; latency start->done = WIDTH+1 edges.
- Back-to-back: start_i held high in S_DONE -> next S_RUN begins on the following edge; throughput one result per WIDTH+1 cycles.
- busy_o and done_o are decoded from the state register only (glitch-free, no input-to-output combinational path).
- Full adder path is purely combinational within one cycle: register -> FA -> register.

## Structure
- Package serial_add_pkg: typedef enum logic [1:0] state_t {S_IDLE, S_RUN, S_DONE}; localparam DEFAULT_WIDTH = 8.
- One sub-module: a single instance of module_full_adder (ports A, B, Cin, S, Cout); no other adder logic in this block.
- The rest is one FSM plus the counter, shift and carry registers.

## Test plan
- WIDTH=8, add, a=0x5A, b=0x3C, cin=0 -> after 9 edges done_o=1, sum_o=0x96, cout_o=0, ovf_o=1; busy_o high exactly 8 cycles.
- Add a=0xFF, b=0x01, cin=0 -> sum_o=0x00, cout_o=1, ovf_o=0; add a=0x00, b=0x00, cin=1 -> sum_o=0x01, cout_o=0.
- Subtract a=0x10, b=0x20 -> sum_o=0xF0, cout_o=0, ovf_o=0; subtract a=0x80, b=0x01 -> sum_o=0x7F, cout_o=1, ovf_o=1.
- start_i pulsed again at run cycle 3 with different operands -> ignored; result matches the first operands; single done pulse.
- start_i held high through S_DONE with new operands 0x01+0x01 -> next S_RUN begins immediately; second done_o arrives 9 cycles after the first with sum_o=0x02.
- rst asserted at run cycle 4 -> next edge busy_o=0, sum_o=0, cout_o=0, ovf_o=0, no done_o; a fresh start then completes normally.
